// File: rtl/adc_scan_if.sv
// ADC core handshake bundle: conversion start/channel towards the core,
// done pulse and 8-bit result back from it.
interface adc_scan_if #(
    parameter int CH_W = 1
);
    logic            adc_init;
    logic [CH_W-1:0] adc_channel;
    logic            adc_done;
    logic [7:0]      adc_data;

    // Sequencer side drives start/channel and listens for the result
    modport master (
        output adc_init,
        output adc_channel,
        input  adc_done,
        input  adc_data
    );

    // ADC core side
    modport slave (
        input  adc_init,
        input  adc_channel,
        output adc_done,
        output adc_data
    );
endinterface

// File: rtl/adc_scan_sequencer.sv
// Autonomous ADC scan controller: walks the latched channel mask in ascending
// order, converts each channel, stores results in a per-channel bank, and
// supports single-shot / continuous scans with an inter-scan gap and a
// done-timeout watchdog.
// Optional build macro ADC_SCAN_AVG_EN: convert every channel twice and
// store the truncated average of the two results.
module adc_scan_sequencer #(
    parameter int N_CH     = 2,
    parameter int CH_W     = 1,
    parameter int TIMEOUT  = 4096,
    parameter int SCAN_GAP = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             cont,
    input  logic             stop,
    input  logic [N_CH-1:0]  ch_mask,
    adc_scan_if.master       adc,
    input  logic [CH_W-1:0]  rd_ch,
    output logic [7:0]       rd_data,
    output logic             busy,
    output logic             scan_done,
    output logic             timeout_err,
    input  logic             err_clr
);

    localparam int TO_W  = (TIMEOUT  > 1) ? $clog2(TIMEOUT)  : 1;
    localparam int GAP_W = (SCAN_GAP > 1) ? $clog2(SCAN_GAP) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        STORE,
        NEXT,
        GAP
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [N_CH-1:0]   mask_q;
    logic [N_CH-1:0]   mask_next;
    logic [CH_W-1:0]   ch;
    logic [CH_W-1:0]   ch_next;
    logic [CH_W-1:0]   higher_ch;
    logic              higher_found;
    logic [CH_W-1:0]   low_in;
    logic [CH_W-1:0]   low_q;
    logic [TO_W-1:0]   wait_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic [7:0]        hold;
    logic [7:0]        result [N_CH];
    logic [7:0]        rd_next;
    logic              stop_pend;
    logic              stop_req;
    logic              wait_clr;
    logic              wait_inc;
    logic              hold_load;
    logic              store_en;
    logic              timeout_hit;
    logic              gap_clr;
    logic              gap_inc;
`ifdef ADC_SCAN_AVG_EN
    logic              conv_second;
    logic [8:0]        avg_sum;

    assign avg_sum = {1'b0, hold} + {1'b0, adc.adc_data};
`endif

    assign busy            = (state != IDLE);
    assign adc.adc_channel = ch;
    assign stop_req        = stop_pend | stop;

    // Channel search: next set bit above the current channel, and the lowest
    // set bit of both the incoming and the latched mask
    always_comb begin
        higher_found = 1'b0;
        higher_ch    = '0;
        low_in       = '0;
        low_q        = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (mask_q[i] && (i > int'(ch))) begin
                higher_found = 1'b1;
                higher_ch    = CH_W'(i);
            end
            if (ch_mask[i]) begin
                low_in = CH_W'(i);
            end
            if (mask_q[i]) begin
                low_q = CH_W'(i);
            end
        end
    end

    // Next-state and control decode for the scan FSM
    always_comb begin
        state_next   = state;
        ch_next      = ch;
        mask_next    = mask_q;
        adc.adc_init = 1'b0;
        scan_done    = 1'b0;
        wait_clr     = 1'b0;
        wait_inc     = 1'b0;
        hold_load    = 1'b0;
        store_en     = 1'b0;
        timeout_hit  = 1'b0;
        gap_clr      = 1'b0;
        gap_inc      = 1'b0;
        case (state)
            IDLE: begin
                if (start && (ch_mask != '0)) begin
                    mask_next  = ch_mask;
                    ch_next    = low_in;
                    state_next = START;
                end
            end
            START: begin
                adc.adc_init = 1'b1;
                wait_clr     = 1'b1;
                state_next   = WAIT;
            end
            WAIT: begin
                if (adc.adc_done) begin
                    hold_load = 1'b1;
`ifdef ADC_SCAN_AVG_EN
                    state_next = conv_second ? STORE : START;
`else
                    state_next = STORE;
`endif
                end else if (wait_cnt == TO_W'(TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_next  = NEXT;
                end else begin
                    wait_inc = 1'b1;
                end
            end
            STORE: begin
                store_en   = 1'b1;
                state_next = NEXT;
            end
            NEXT: begin
                if (higher_found) begin
                    ch_next    = higher_ch;
                    state_next = START;
                end else begin
                    scan_done = 1'b1;
                    if (cont && !stop_req && (ch_mask != '0)) begin
                        mask_next = ch_mask;
                        if (SCAN_GAP == 0) begin
                            ch_next    = low_in;
                            state_next = START;
                        end else begin
                            gap_clr    = 1'b1;
                            state_next = GAP;
                        end
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            GAP: begin
                if (stop_req) begin
                    state_next = IDLE;
                end else if (gap_cnt == GAP_W'(SCAN_GAP - 1)) begin
                    ch_next    = low_q;
                    state_next = START;
                end else begin
                    gap_inc = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, channel pointer, latched mask and pending-stop registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ch        <= '0;
            mask_q    <= '0;
            stop_pend <= 1'b0;
        end else begin
            state  <= state_next;
            ch     <= ch_next;
            mask_q <= mask_next;
            if (state_next == IDLE) begin
                stop_pend <= 1'b0;
            end else if (stop && (state != IDLE)) begin
                stop_pend <= 1'b1;
            end
        end
    end

    // Done-timeout and inter-scan gap counters
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
            gap_cnt  <= '0;
        end else begin
            if (wait_clr) begin
                wait_cnt <= '0;
            end else if (wait_inc) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (gap_clr) begin
                gap_cnt <= '0;
            end else if (gap_inc) begin
                gap_cnt <= gap_cnt + 1'b1;
            end
        end
    end

    // Conversion hold register; in averaging builds it first keeps the first
    // sample, then the halved sum of both samples
    always_ff @(posedge clk) begin
        if (reset) begin
            hold <= '0;
`ifdef ADC_SCAN_AVG_EN
            conv_second <= 1'b0;
`endif
        end else if (hold_load) begin
`ifdef ADC_SCAN_AVG_EN
            if (conv_second) begin
                hold <= avg_sum[8:1];
            end else begin
                hold <= adc.adc_data;
            end
            conv_second <= ~conv_second;
`else
            hold <= adc.adc_data;
`endif
        end
`ifdef ADC_SCAN_AVG_EN
        else if (timeout_hit) begin
            conv_second <= 1'b0;
        end
`endif
    end

    // Result bank write and sticky timeout flag (a new timeout beats a clear)
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) begin
                result[i] <= '0;
            end
            timeout_err <= 1'b0;
        end else begin
            if (store_en) begin
                for (int i = 0; i < N_CH; i++) begin
                    if (ch == CH_W'(i)) begin
                        result[i] <= hold;
                    end
                end
            end
            if (timeout_hit) begin
                timeout_err <= 1'b1;
            end else if (err_clr) begin
                timeout_err <= 1'b0;
            end
        end
    end

    // Read mux; indexes beyond the bank read as zero
    always_comb begin
        rd_next = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (rd_ch == CH_W'(i)) begin
                rd_next = result[i];
            end
        end
    end

    // Registered read port
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= rd_next;
        end
    end

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Directed self-checking bench for adc_scan_sequencer with a small ADC core
// model answering each conversion start after a programmable delay.
module tb_adc_scan_sequencer;

    localparam int N_CH     = 2;
    localparam int CH_W     = 2;
    localparam int TIMEOUT  = 16;
    localparam int SCAN_GAP = 10;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            start = 1'b0;
    logic            cont = 1'b0;
    logic            stop = 1'b0;
    logic [N_CH-1:0] ch_mask = '0;
    logic [CH_W-1:0] rd_ch = '0;
    logic [7:0]      rd_data;
    logic            busy;
    logic            scan_done;
    logic            timeout_err;
    logic            err_clr = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [7:0] core_val [4];
    logic [7:0] seq_data [$];
    bit         core_en = 1'b1;
    int         core_delay = 5;
    int         pend_cnt = 0;
    logic [CH_W-1:0] pend_ch = '0;

    int cyc = 0;
    int busy_cyc = 0;
    int init_cyc [$];
    int init_ch [$];
    int done_cyc [$];

    adc_scan_if #(.CH_W(CH_W)) adc_bus ();

    adc_scan_sequencer #(
        .N_CH(N_CH),
        .CH_W(CH_W),
        .TIMEOUT(TIMEOUT),
        .SCAN_GAP(SCAN_GAP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .cont(cont),
        .stop(stop),
        .ch_mask(ch_mask),
        .adc(adc_bus.master),
        .rd_ch(rd_ch),
        .rd_data(rd_data),
        .busy(busy),
        .scan_done(scan_done),
        .timeout_err(timeout_err),
        .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    // ADC core model: answers each adc_init after core_delay cycles
    initial begin
        adc_bus.adc_done = 1'b0;
        adc_bus.adc_data = 8'h00;
        forever begin
            @(negedge clk);
            adc_bus.adc_done = 1'b0;
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    adc_bus.adc_done = 1'b1;
                    if (seq_data.size() > 0) adc_bus.adc_data = seq_data.pop_front();
                    else adc_bus.adc_data = core_val[pend_ch];
                end
            end
            if (adc_bus.adc_init && core_en) begin
                pend_cnt = core_delay;
                pend_ch  = adc_bus.adc_channel;
            end
        end
    end

    // Event monitor: logs init/done cycles and busy cycles
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (adc_bus.adc_init) begin
                init_cyc.push_back(cyc);
                init_ch.push_back(int'(adc_bus.adc_channel));
            end
            if (scan_done) done_cyc.push_back(cyc);
            if (busy) busy_cyc++;
        end
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        step(1);
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic run_until_idle(input int budget, output bit ok, output bit err_seen);
        ok = 1'b0;
        err_seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step(1);
            if (timeout_err) err_seen = 1'b1;
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic read_result(input logic [CH_W-1:0] idx, output logic [7:0] val);
        rd_ch = idx;
        step(1);
        val = rd_data;
    endtask

    task automatic do_reset();
        step(1);
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(1);
    endtask

    task automatic test_reset();
        logic [7:0] v;
        $display("[TB] test_reset");
        step(1);
        reset = 1'b1;
        step(3);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (adc_bus.adc_init !== 1'b0) begin errors++; $display("[TB] FAIL reset_init: got %b expected 0", adc_bus.adc_init); end
        checks++; if (adc_bus.adc_channel !== 2'd0) begin errors++; $display("[TB] FAIL reset_channel: got %0d expected 0", adc_bus.adc_channel); end
        checks++; if (scan_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_scan_done: got %b expected 0", scan_done); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_timeout_err: got %b expected 0", timeout_err); end
        checks++; if (rd_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_rd_data: got %h expected 00", rd_data); end
        reset = 1'b0;
        read_result(2'd1, v);
        checks++; if (v !== 8'h00) begin errors++; $display("[TB] FAIL reset_result1: got %h expected 00", v); end
    endtask

    task automatic test_single_scan();
        int bi, bd, bb;
        bit ok, es;
        logic [7:0] v;
        $display("[TB] test_single_scan");
        core_val[0] = 8'h3C;
        core_val[1] = 8'hA5;
        core_delay = 5;
        ch_mask = 2'b11;
        cont = 1'b0;
        bi = init_cyc.size(); bd = done_cyc.size(); bb = busy_cyc;
        pulse_start();
        run_until_idle(60, ok, es);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL single_idle: busy stuck high, expected idle within 60 cycles"); end
        checks++; if (init_cyc.size() - bi != 2) begin errors++; $display("[TB] FAIL single_init_count: got %0d expected 2", init_cyc.size() - bi); end
        if (init_cyc.size() - bi >= 2) begin
            checks++; if (init_ch[bi] != 0 || init_ch[bi+1] != 1) begin errors++; $display("[TB] FAIL single_channels: got %0d,%0d expected 0,1", init_ch[bi], init_ch[bi+1]); end
        end
        checks++; if (done_cyc.size() - bd != 1) begin errors++; $display("[TB] FAIL single_done_count: got %0d expected 1", done_cyc.size() - bd); end
        checks++; if (busy_cyc - bb != 16) begin errors++; $display("[TB] FAIL single_busy_cycles: got %0d expected 16", busy_cyc - bb); end
        read_result(2'd1, v);
        checks++; if (v !== 8'hA5) begin errors++; $display("[TB] FAIL single_rd1: got %h expected a5", v); end
        read_result(2'd0, v);
        checks++; if (v !== 8'h3C) begin errors++; $display("[TB] FAIL single_rd0: got %h expected 3c", v); end
        read_result(2'd3, v);
        checks++; if (v !== 8'h00) begin errors++; $display("[TB] FAIL single_rd_out_of_range: got %h expected 00", v); end
    endtask

    task automatic test_mask();
        int bi, bd, bb;
        bit ok, es;
        logic [7:0] v;
        $display("[TB] test_mask");
        do_reset();
        core_val[1] = 8'h5A;
        ch_mask = 2'b10;
        bi = init_cyc.size(); bd = done_cyc.size(); bb = busy_cyc;
        pulse_start();
        run_until_idle(40, ok, es);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL mask_idle: busy stuck high, expected idle within 40 cycles"); end
        checks++; if (init_cyc.size() - bi != 1) begin errors++; $display("[TB] FAIL mask_init_count: got %0d expected 1", init_cyc.size() - bi); end
        if (init_cyc.size() - bi >= 1) begin
            checks++; if (init_ch[bi] != 1) begin errors++; $display("[TB] FAIL mask_channel: got %0d expected 1", init_ch[bi]); end
        end
        checks++; if (busy_cyc - bb != 8) begin errors++; $display("[TB] FAIL mask_busy_cycles: got %0d expected 8", busy_cyc - bb); end
        read_result(2'd0, v);
        checks++; if (v !== 8'h00) begin errors++; $display("[TB] FAIL mask_rd0: got %h expected 00", v); end
        read_result(2'd1, v);
        checks++; if (v !== 8'h5A) begin errors++; $display("[TB] FAIL mask_rd1: got %h expected 5a", v); end
        ch_mask = 2'b00;
        bi = init_cyc.size();
        pulse_start();
        step(5);
        checks++; if (busy !== 1'b0 || init_cyc.size() != bi) begin errors++; $display("[TB] FAIL zero_mask_ignored: got busy=%b inits=%0d expected busy=0 inits=0", busy, init_cyc.size() - bi); end
    endtask

    task automatic test_timeout();
        int bi, bd, bb;
        bit ok, es;
        logic [7:0] v;
        $display("[TB] test_timeout");
        core_en = 1'b0;
        ch_mask = 2'b10;
        bi = init_cyc.size(); bd = done_cyc.size(); bb = busy_cyc;
        pulse_start();
        run_until_idle(60, ok, es);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL timeout_idle: busy stuck high, expected idle within 60 cycles"); end
        checks++; if (busy_cyc - bb != 18) begin errors++; $display("[TB] FAIL timeout_busy_cycles: got %0d expected 18", busy_cyc - bb); end
        checks++; if (done_cyc.size() - bd != 1) begin errors++; $display("[TB] FAIL timeout_done_count: got %0d expected 1", done_cyc.size() - bd); end
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("[TB] FAIL timeout_flag: got %b expected 1", timeout_err); end
        step(3);
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("[TB] FAIL timeout_sticky: got %b expected 1", timeout_err); end
        read_result(2'd1, v);
        checks++; if (v !== 8'h5A) begin errors++; $display("[TB] FAIL timeout_result_kept: got %h expected 5a", v); end
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL err_clr: got %b expected 0", timeout_err); end
        err_clr = 1'b1;
        pulse_start();
        run_until_idle(60, ok, es);
        checks++; if (es !== 1'b1) begin errors++; $display("[TB] FAIL timeout_set_wins: flag seen=%b expected 1", es); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL timeout_clr_after: got %b expected 0", timeout_err); end
        err_clr = 1'b0;
        core_en = 1'b1;
        step(2);
    endtask

    task automatic test_continuous();
        int bi, bd;
        bit ok, es;
        $display("[TB] test_continuous");
        core_val[0] = 8'h11;
        core_val[1] = 8'h22;
        ch_mask = 2'b11;
        cont = 1'b1;
        bi = init_cyc.size(); bd = done_cyc.size();
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (done_cyc.size() - bd >= 1) begin ok = 1'b1; break; end
        end
        start = 1'b1;
        step(1);
        start = 1'b0;
        for (int i = 0; i < 100 && ok; i++) begin
            step(1);
            if (init_cyc.size() - bi >= 5) break;
            if (i == 99) ok = 1'b0;
        end
        checks++; if (!ok) begin errors++; $display("[TB] FAIL cont_progress: third scan not reached, scans done=%0d", done_cyc.size() - bd); end
        step(2);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        run_until_idle(60, ok, es);
        cont = 1'b0;
        checks++; if (!ok) begin errors++; $display("[TB] FAIL cont_stop_idle: busy stuck high after stop"); end
        checks++; if (done_cyc.size() - bd != 3) begin errors++; $display("[TB] FAIL cont_done_count: got %0d expected 3", done_cyc.size() - bd); end
        checks++; if (init_cyc.size() - bi != 6) begin errors++; $display("[TB] FAIL cont_init_count: got %0d expected 6", init_cyc.size() - bi); end
        if (init_cyc.size() - bi >= 5 && done_cyc.size() - bd >= 2) begin
            checks++; if (init_cyc[bi+2] - done_cyc[bd] != 11) begin errors++; $display("[TB] FAIL cont_gap1: got %0d expected 11", init_cyc[bi+2] - done_cyc[bd]); end
            checks++; if (init_cyc[bi+4] - done_cyc[bd+1] != 11) begin errors++; $display("[TB] FAIL cont_gap2: got %0d expected 11", init_cyc[bi+4] - done_cyc[bd+1]); end
            checks++; if (init_ch[bi+2] != 0 || init_ch[bi+3] != 1) begin errors++; $display("[TB] FAIL cont_scan2_channels: got %0d,%0d expected 0,1", init_ch[bi+2], init_ch[bi+3]); end
        end
    endtask

    task automatic test_stop_in_gap();
        int bi, bd;
        bit ok;
        $display("[TB] test_stop_in_gap");
        ch_mask = 2'b11;
        cont = 1'b1;
        bi = init_cyc.size(); bd = done_cyc.size();
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (done_cyc.size() - bd >= 1) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin errors++; $display("[TB] FAIL gapstop_first_scan: no scan_done within 100 cycles"); end
        step(3);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        cont = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL gapstop_idle: got busy=%b expected 0", busy); end
        step(15);
        checks++; if (init_cyc.size() - bi != 2) begin errors++; $display("[TB] FAIL gapstop_init_count: got %0d expected 2", init_cyc.size() - bi); end
        checks++; if (done_cyc.size() - bd != 1) begin errors++; $display("[TB] FAIL gapstop_done_count: got %0d expected 1", done_cyc.size() - bd); end
    endtask

    task automatic test_reset_mid_conversion();
        int bi;
        logic [7:0] v;
        $display("[TB] test_reset_mid_conversion");
        core_val[0] = 8'h77;
        core_delay = 5;
        ch_mask = 2'b01;
        bi = init_cyc.size();
        pulse_start();
        step(2);
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(4);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_busy: got %b expected 0", busy); end
        checks++; if (init_cyc.size() - bi != 1) begin errors++; $display("[TB] FAIL rstmid_init_count: got %0d expected 1", init_cyc.size() - bi); end
        checks++; if (adc_bus.adc_channel !== 2'd0 || timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_outputs: got ch=%0d err=%b expected 0 0", adc_bus.adc_channel, timeout_err); end
        read_result(2'd0, v);
        checks++; if (v !== 8'h00) begin errors++; $display("[TB] FAIL rstmid_rd0: got %h expected 00", v); end
        read_result(2'd1, v);
        checks++; if (v !== 8'h00) begin errors++; $display("[TB] FAIL rstmid_rd1: got %h expected 00", v); end
    endtask

`ifdef ADC_SCAN_AVG_EN
    task automatic test_average();
        int bi;
        bit ok, es;
        logic [7:0] v;
        $display("[TB] test_average");
        do_reset();
        ch_mask = 2'b01;
        seq_data.push_back(8'h10);
        seq_data.push_back(8'h13);
        bi = init_cyc.size();
        pulse_start();
        run_until_idle(60, ok, es);
        checks++; if (init_cyc.size() - bi != 2) begin errors++; $display("[TB] FAIL avg_init_count: got %0d expected 2", init_cyc.size() - bi); end
        read_result(2'd0, v);
        checks++; if (v !== 8'h11) begin errors++; $display("[TB] FAIL avg_result: got %h expected 11", v); end
        seq_data.push_back(8'hFF);
        seq_data.push_back(8'hFF);
        pulse_start();
        run_until_idle(60, ok, es);
        read_result(2'd0, v);
        checks++; if (v !== 8'hFF) begin errors++; $display("[TB] FAIL avg_no_overflow: got %h expected ff", v); end
    endtask
`endif

    // Test sequence
    initial begin
        for (int i = 0; i < 4; i++) core_val[i] = 8'h00;
        test_reset();
        test_single_scan();
        test_mask();
        test_timeout();
        test_continuous();
        test_stop_in_gap();
        test_reset_mid_conversion();
`ifdef ADC_SCAN_AVG_EN
        test_average();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
